// File: rtl/fixed_point_div_pkg.sv
// Shared types and sizing helpers for the sequential sign-magnitude divider.
package fixed_point_div_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Quotient register width: N-1+Q result bits plus one guard bit.
   function automatic int calc_k(input int n, input int q);
      return n + q;
   endfunction

   // Width of the iteration counter that counts K restoring steps down to 1.
   function automatic int cnt_width(input int n, input int q);
      return $clog2(n + q + 1);
   endfunction

endpackage

// File: rtl/fpd_round_sat.sv
// Guard-bit rounding, saturation and sign fix-up for the raw K-bit quotient.
module fpd_round_sat
   import fixed_point_div_pkg::*;
#(
   parameter int N = 32,
   parameter int Q = 3
) (
   input  logic [calc_k(N, Q)-1:0] quo_raw_i,
   input  logic                    round_en_i,
   input  logic                    sign_i,
   output logic [N-1:0]            quotient_o,
   output logic                    overflow_o
);

   localparam int K = calc_k(N, Q);

   logic [K-1:0]   mag_ext_s;
   logic [N-2:0]   mag_s;
   logic           sat_s;

   // Drop the guard bit, optionally add it back as a half-up round, then clamp.
   always_comb begin
      mag_ext_s = {1'b0, quo_raw_i[K-1:1]}
                + {{(K-1){1'b0}}, (round_en_i & quo_raw_i[0])};
      sat_s     = |mag_ext_s[K-1:N-1];
      if (sat_s) begin
         mag_s = {(N-1){1'b1}};
      end else begin
         mag_s = mag_ext_s[N-2:0];
      end
      overflow_o = sat_s;
      // A zero magnitude is always reported as positive zero.
      quotient_o = {(sign_i & (|mag_s)), mag_s};
   end

endmodule

// File: rtl/fixed_point_divider_seq.sv
// Radix-2 restoring sign-magnitude fixed-point divider with valid/ready on
// both sides, optional round-half-up, saturation and divide-by-zero flag.
module fixed_point_divider_seq
   import fixed_point_div_pkg::*;
#(
   parameter int N = 32,
   parameter int Q = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   input  logic         round_en,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic         overflow,
   output logic         div_by_zero
);

   localparam int K  = calc_k(N, Q);
   localparam int CW = cnt_width(N, Q);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-2:0]   rem_q, rem_d;     // remainder always stays below the divisor
   logic [K-1:0]   num_q, num_d;
   logic [K-1:0]   quo_q, quo_d;
   logic [N-2:0]   dmag_q, dmag_d;
   logic           sign_q, sign_d;
   logic           rnd_q, rnd_d;
   logic [N-1:0]   quotient_q, quotient_d;
   logic           overflow_q, overflow_d;
   logic           dbz_q, dbz_d;

   logic [N-1:0]   rem_shift_s;
   logic [N:0]     sub_s;
   logic           ge_s;
   logic           unused_s;
   logic [N-1:0]   rs_quotient_s;
   logic           rs_overflow_s;

   // One restoring step: shift in the next numerator bit and trial-subtract.
   always_comb begin
      rem_shift_s = {rem_q, num_q[K-1]};
      sub_s       = {1'b0, rem_shift_s} - {2'b00, dmag_q};
      ge_s        = ~sub_s[N];
      // Bit N-1 of a successful difference is always zero (result < divisor).
      unused_s    = sub_s[N-1];
   end

   fpd_round_sat #(
      .N (N),
      .Q (Q)
   ) u_round_sat (
      .quo_raw_i  (quo_q),
      .round_en_i (rnd_q),
      .sign_i     (sign_q),
      .quotient_o (rs_quotient_s),
      .overflow_o (rs_overflow_s)
   );

   // Next-state and datapath control for IDLE -> CALC -> ROUND -> DONE.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      num_d      = num_q;
      quo_d      = quo_q;
      dmag_d     = dmag_q;
      sign_d     = sign_q;
      rnd_d      = rnd_q;
      quotient_d = quotient_q;
      overflow_d = overflow_q;
      dbz_d      = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               dmag_d = divisor[N-2:0];
               num_d  = {dividend[N-2:0], {(Q+1){1'b0}}};
               rem_d  = {(N-1){1'b0}};
               quo_d  = {K{1'b0}};
               cnt_d  = CW'(K);
               sign_d = dividend[N-1] ^ divisor[N-1];
               rnd_d  = round_en;
               if (divisor[N-2:0] == {(N-1){1'b0}}) begin
                  // Divide by zero skips the iteration; a -0 dividend reads as +0.
                  quotient_d = {(dividend[N-1] & (|dividend[N-2:0])), {(N-1){1'b1}}};
                  overflow_d = 1'b0;
                  dbz_d      = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  state_d    = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            rem_d = ge_s ? sub_s[N-2:0] : rem_shift_s[N-2:0];
            num_d = {num_q[K-2:0], 1'b0};
            quo_d = {quo_q[K-2:0], ge_s};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_ROUND;
            end else begin
               state_d = S_CALC;
            end
         end
         S_ROUND: begin
            quotient_d = rs_quotient_s;
            overflow_d = rs_overflow_s;
            dbz_d      = 1'b0;
            state_d    = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, iteration and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= {CW{1'b0}};
         rem_q      <= {(N-1){1'b0}};
         num_q      <= {K{1'b0}};
         quo_q      <= {K{1'b0}};
         dmag_q     <= {(N-1){1'b0}};
         sign_q     <= 1'b0;
         rnd_q      <= 1'b0;
         quotient_q <= {N{1'b0}};
         overflow_q <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         num_q      <= num_d;
         quo_q      <= quo_d;
         dmag_q     <= dmag_d;
         sign_q     <= sign_d;
         rnd_q      <= rnd_d;
         quotient_q <= quotient_d;
         overflow_q <= overflow_d;
         dbz_q      <= dbz_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign quotient    = quotient_q;
   assign overflow    = overflow_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_point_divider_seq.sv
// Self-checking bench: directed and random divisions against an arithmetic model.
module tb_fixed_point_divider_seq;

   localparam int N = 32;
   localparam int Q = 3;
   localparam int K = N + Q;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  dividend;
   logic [N-1:0]  divisor;
   logic          round_en;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  quotient;
   logic          overflow;
   logic          div_by_zero;

   int errors = 0;
   int checks = 0;

   fixed_point_divider_seq #(.N(N), .Q(Q)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .round_en    (round_en),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer division of the scaled magnitudes.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic r, output logic [31:0] q,
                                 output logic ovf, output logic dbz);
      logic [63:0] ma, mb, scaled, m;
      ma = {33'd0, a[30:0]};
      mb = {33'd0, b[30:0]};
      if (mb == 64'd0) begin
         q   = {(a[31] && ma != 64'd0), 31'h7FFFFFFF};
         ovf = 1'b0;
         dbz = 1'b1;
      end else begin
         scaled = (ma << (Q + 1)) / mb;
         m      = scaled >> 1;
         if (r) m = m + (scaled % 64'd2);
         ovf = 1'b0;
         if (m >= 64'h80000000) begin
            m   = 64'h7FFFFFFF;
            ovf = 1'b1;
         end
         q   = {(a[31] ^ b[31]) && (m != 64'd0), m[30:0]};
         dbz = 1'b0;
      end
   endfunction

   // Present one operand set, wait for the result (no consume); lat=-1 on timeout.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic r,
                         output logic [31:0] q, output logic ovf, output logic dbz,
                         output int lat);
      @(negedge clk);
      dividend  = a;
      divisor   = b;
      round_en  = r;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      round_en = ~r;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      q   = quotient;
      ovf = overflow;
      dbz = div_by_zero;
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0; round_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || quotient !== 32'h0 || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got ov=%b q=%h ovf=%b dbz=%b, want 0 0 0 0",
                  out_valid, quotient, overflow, div_by_zero);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      logic [31:0] a_t [6];
      logic [31:0] b_t [6];
      logic        r_t [6];
      logic [31:0] exp_t [6];
      logic [31:0] q, eq;
      logic        ovf, dbz, eo, ed;
      int          lat, elat;
      a_t = '{32'h00000050, 32'h8000003C, 32'h00000000, 32'h00000008, 32'h00000008, 32'h7FFFFFFF};
      b_t = '{32'h00000020, 32'h00000010, 32'h80000010, 32'h00000018, 32'h00000018, 32'h00000001};
      r_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_t = '{32'h00000014, 32'h8000001E, 32'h00000000, 32'h00000002, 32'h00000003, 32'h7FFFFFFF};
      for (int i = 0; i < 6; i++) begin
         run_op(a_t[i], b_t[i], r_t[i], q, ovf, dbz, lat);
         model(a_t[i], b_t[i], r_t[i], eq, eo, ed);
         checks++;
         if (q !== exp_t[i] || q !== eq) begin
            errors++;
            $display("FAIL directed_q[%0d]: got %h want %h", i, q, exp_t[i]);
         end
         checks++;
         if (ovf !== (i == 5) || dbz !== 1'b0) begin
            errors++;
            $display("FAIL directed_flags[%0d]: got ovf=%b dbz=%b want ovf=%b dbz=0", i, ovf, dbz, (i == 5));
         end
         elat = K + 1;
         checks++;
         if (lat !== elat) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, elat);
         end
         consume();
      end
   endtask

   task automatic test_div_by_zero();
      logic [31:0] q;
      logic        ovf, dbz;
      int          lat;
      run_op(32'h00000008, 32'h80000000, 1'b0, q, ovf, dbz, lat);
      checks++;
      if (q !== 32'h7FFFFFFF || dbz !== 1'b1 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL dbz_pos: got q=%h dbz=%b ovf=%b want 7fffffff 1 0", q, dbz, ovf);
      end
      checks++;
      if (lat !== 0) begin
         errors++;
         $display("FAIL dbz_latency: got %0d want 0 extra edges", lat);
      end
      consume();
      run_op(32'h80000005, 32'h00000000, 1'b1, q, ovf, dbz, lat);
      checks++;
      if (q !== 32'hFFFFFFFF || dbz !== 1'b1 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL dbz_neg: got q=%h dbz=%b ovf=%b want ffffffff 1 0", q, dbz, ovf);
      end
      consume();
   endtask

   task automatic test_backpressure();
      logic [31:0] q0, q;
      logic        o0, d0, ovf, dbz;
      int          lat, bad;
      run_op(32'h8000003C, 32'h00000010, 1'b0, q0, o0, d0, lat);
      @(negedge clk);
      dividend = 32'h00000050; divisor = 32'h00000020; round_en = 1'b0;
      in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== q0 ||
             overflow !== o0 || div_by_zero !== d0) begin
            errors++;
            $display("FAIL hold[%0d]: got ov=%b rdy=%b q=%h want 1 0 %h", i, out_valid, in_ready, quotient, q0);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release: got ov=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL next_accept: got in_ready=%b want 0", in_ready);
      end
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      q = quotient; ovf = overflow; dbz = div_by_zero;
      checks++;
      if (q !== 32'h00000014 || ovf !== 1'b0 || dbz !== 1'b0 || lat !== K + 1) begin
         errors++;
         $display("FAIL after_hold: got q=%h ovf=%b dbz=%b lat=%0d want 00000014 0 0 %0d", q, ovf, dbz, lat, K + 1);
      end
      consume();
   endtask

   task automatic test_reset_abort();
      logic [31:0] q;
      logic        ovf, dbz;
      int          lat, seen;
      @(negedge clk);
      dividend = 32'h00000050; divisor = 32'h00000020; round_en = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 32'h0) begin
         errors++;
         $display("FAIL abort_async: got ov=%b rdy=%b q=%h want 0 1 0", out_valid, in_ready, quotient);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_no_result: got %0d valid cycles rdy=%b want 0 1", seen, in_ready);
      end
      run_op(32'h00000050, 32'h00000020, 1'b0, q, ovf, dbz, lat);
      checks++;
      if (q !== 32'h00000014 || ovf !== 1'b0 || dbz !== 1'b0 || lat !== K + 1) begin
         errors++;
         $display("FAIL abort_next: got q=%h ovf=%b dbz=%b lat=%0d want 00000014 0 0 %0d", q, ovf, dbz, lat, K + 1);
      end
      consume();
   endtask

   task automatic test_random();
      logic [31:0] a, b, q, eq;
      logic        r, ovf, dbz, eo, ed;
      int          lat, sel;
      for (int i = 0; i < 40; i++) begin
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 4);
         if (sel == 0) b[30:0] = 31'($urandom_range(0, 40));
         else if (sel == 1) b[30:0] = b[30:0] >> $urandom_range(8, 30);
         else if (sel == 2) a[30:0] = a[30:0] >> $urandom_range(4, 30);
         else a = a;
         r = 1'($urandom_range(0, 1));
         run_op(a, b, r, q, ovf, dbz, lat);
         model(a, b, r, eq, eo, ed);
         checks++;
         if (q !== eq || ovf !== eo || dbz !== ed || lat !== (ed ? 0 : K + 1)) begin
            errors++;
            $display("FAIL random[%0d] a=%h b=%h r=%b: got q=%h ovf=%b dbz=%b lat=%0d want %h %b %b %0d",
                     i, a, b, r, q, ovf, dbz, lat, eq, eo, ed, (ed ? 0 : K + 1));
         end
         consume();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a_t [3];
      logic [31:0] b_t [3];
      logic [31:0] exp_q [$];
      logic [31:0] eq;
      logic        eo, ed, prev_ready;
      int          edges, idx, last_acc, got;
      a_t = '{32'h00000050, 32'h8000003C, 32'h00000123};
      b_t = '{32'h00000020, 32'h00000010, 32'h80000007};
      @(negedge clk);
      out_ready = 1'b1;
      round_en  = 1'b1;
      dividend  = a_t[0];
      divisor   = b_t[0];
      in_valid  = 1'b1;
      idx = 0; edges = 0; last_acc = -1; got = 0;
      prev_ready = in_ready;
      while ((idx < 3 || got < 3) && edges < 500) begin
         @(posedge clk); #1;
         edges++;
         if (out_valid) begin
            got++;
            checks++;
            if (exp_q.size() == 0 || quotient !== exp_q[0]) begin
               errors++;
               $display("FAIL b2b_q[%0d]: got %h want %h", got, quotient,
                        (exp_q.size() == 0) ? 32'hx : exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         if (prev_ready && !in_ready) begin
            if (last_acc >= 0) begin
               checks++;
               if (edges - last_acc !== K + 3) begin
                  errors++;
                  $display("FAIL b2b_interval: got %0d want %0d", edges - last_acc, K + 3);
               end
            end
            last_acc = edges;
            model(a_t[idx], b_t[idx], 1'b1, eq, eo, ed);
            exp_q.push_back(eq);
            idx++;
            if (idx < 3) begin
               dividend = a_t[idx];
               divisor  = b_t[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
         prev_ready = in_ready;
      end
      checks++;
      if (got !== 3 || idx !== 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d results %0d accepts want 3 3", got, idx);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_by_zero();
      test_backpressure();
      test_reset_abort();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fixed_point_divider_seq.md
# fixed_point_divider_seq

Parametrised sign-magnitude fixed-point divider, successor to the fixed 32-bit/Q3 divider used in the USB2Peripheral math path. Operands and result share one format: bit N-1 is the sign, bits N-2:0 the magnitude with Q fractional bits. It adds a valid/ready handshake on both sides, selectable round-to-nearest, saturation with an overflow flag, and divide-by-zero detection. It is a radix-2 restoring iterative unit sitting between the command decoder and the result FIFO.

## Interface
- N, 32: total word width including the sign bit (N ≥ 4).
- Q, 3: fractional bits (0 ≤ Q ≤ N-2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  divider can accept operands (high only in IDLE).
- dividend  in  N  sign-magnitude dividend, sampled on accept.
- divisor  in  N  sign-magnitude divisor, sampled on accept.
- round_en  in  1  1 = round half-up on magnitude, 0 = truncate; sampled on accept.
- out_valid  out  1  result valid, held until consumed.
- out_ready  in  1  consumer accepts result.
- quotient  out  N  sign-magnitude result.
- overflow  out  1  magnitude saturated; valid with out_valid.
- div_by_zero  out  1  divisor magnitude was zero; valid with out_valid.

## Operation
- Accept: in_valid & in_ready at a clk edge. Operands and round_en are registered; later input changes are ignored.
- Let K = N+Q: that is N-1+Q quotient bits plus 1 guard bit. The numerator is the dividend magnitude shifted left by Q+1, giving K bits.
- FSM: IDLE → CALC → ROUND → DONE → IDLE.
- IDLE → CALC on accept. If the divisor magnitude is 0, IDLE → DONE instead.
- CALC runs K cycles. Each cycle does one restoring step: remainder (N bits) shifts in the next numerator bit, trial-subtracts the divisor magnitude, and shifts the quotient bit into a K-bit register.
- ROUND (1 cycle):
  - Drop the guard bit.
  - If round_en is set, add the guard bit to the magnitude.
  - If the magnitude is ≥ 2^(N-1), set it to all-ones and set overflow.
- DONE: out_valid=1. Leave to IDLE on out_ready.
- Sign:
  - Result sign is dividend sign XOR divisor sign.
  - A zero magnitude result is forced to sign 0.
  - A negative-zero input is treated as zero.
- Divide by zero: magnitude is all-ones, sign is the dividend sign, div_by_zero=1, overflow=0.
- quotient, overflow and div_by_zero are registered. They change only on entry to DONE and hold stable while out_valid is high.

## Timing
- Reset values (while rst is high and after release): state IDLE, out_valid 0, quotient 0, overflow 0, div_by_zero 0, in_ready 1 after release.
- Latency: accept at edge t0 → out_valid high from edge t0+K+1. For N=32, Q=3 that is t0+36.
- Divide-by-zero latency: out_valid from edge t0+1.
- in_ready is combinational from state (IDLE). It is 0 in CALC, ROUND and DONE, so accept is never possible while a result is pending.
- Output handshake at edge t: IDLE at t, in_ready high in cycle t. A new accept is possible at edge t+1.
- Minimum issue interval is K+3 cycles.
- Backpressure: out_valid and data are held indefinitely while out_ready is low.
- rst asserted mid-CALC or mid-DONE:
  - Immediate return to IDLE; the pending result is discarded.
  - No out_valid is produced for the aborted operation.

## Structure
- Package fixed_point_div_pkg holds:
  - the state enum (IDLE, CALC, ROUND, DONE);
  - the K = N+Q helper function;
  - the iteration-counter width function, $clog2(K+1).
- One natural sub-module, fpd_round_sat: combinational guard-bit rounding, saturation and sign fix-up, producing {quotient, overflow}. It is instantiated in ROUND.
- Top: FSM, iteration counter, remainder/quotient datapath, and output registers.

## Test plan
- N=32, Q=3, round_en=0: dividend 0x00000050 (10.0), divisor 0x00000020 (4.0) → quotient 0x00000014 (2.5), flags 0, out_valid at t0+36.
- Dividend 0x8000003C (-7.5), divisor 0x00000010 (2.0) → 0x8000001E (-3.75). Then dividend 0x00000000, divisor 0x80000010 → 0x00000000 (positive zero).
- Dividend 0x00000008, divisor 0x00000018 (1/3): round_en=0 → 0x00000002; round_en=1 → 0x00000003.
- Dividend 0x00000008, divisor 0x80000000 → quotient 0x7FFFFFFF, div_by_zero=1, out_valid at t0+1. Dividend 0x7FFFFFFF, divisor 0x00000001 → 0x7FFFFFFF, overflow=1.
- Hold out_ready=0 for 20 cycles after out_valid → data and flags stable, in_ready=0, second in_valid not accepted. Release → handshake, then accept of the next operands.
- Assert rst at accept+10 → out_valid stays 0 and in_ready=1 after release. The next division (80/32) completes correctly.
